// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer, mid-bit sampling,
// held-byte handshake (rcv/rd) and sticky framing/overrun flags.
module uart_rx #(
    parameter int BAUD = 104
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr,
    output logic       ovr,
    output logic       busy
);

    localparam logic [15:0] FULL = 16'(BAUD - 1);
    localparam logic [15:0] HALF = 16'(BAUD / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITHI
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic        rx_meta;
    logic        rxs;

    logic at_full;
    logic at_half;
    logic stop_hit;
    logic accept;
    logic frame_err;

    assign at_full   = (cnt == FULL);
    assign at_half   = (cnt == HALF);
    assign stop_hit  = (state == STOP) && at_full;
    assign accept    = stop_hit && rxs;
    assign frame_err = stop_hit && !rxs;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            data    <= '0;
            rcv     <= 1'b0;
            ferr    <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;

            // Later assignments win: accept and framing error override rd.
            if (rd) begin
                rcv  <= 1'b0;
                ferr <= 1'b0;
                ovr  <= 1'b0;
            end
            if (accept) begin
                if (!rcv || rd) begin
                    data <= shreg;
                    rcv  <= 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end
            if (frame_err) begin
                ferr <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) state <= START;
                end
                START: begin
                    if (at_half) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (at_full) begin
                        shreg <= {rxs, shreg[7:1]};
                        cnt   <= '0;
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (at_full) begin
                        cnt   <= '0;
                        state <= rxs ? IDLE : WAITHI;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAITHI: begin
                    cnt <= '0;
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: BAUD=8 instance for the functional cases,
// BAUD=104 instance for the mid-frame reset case.
module tb_uart_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8;
    logic       rst104;
    logic       rx;
    logic       rd;
    logic [7:0] data8;
    logic       rcv8;
    logic       ferr8;
    logic       ovr8;
    logic       busy8;
    logic [7:0] data104;
    logic       rcv104;
    logic       ferr104;
    logic       ovr104;
    logic       busy104;

    int   n_cmp = 0;
    int   n_err = 0;
    logic pre_rcv;
    logic post_rcv;

    uart_rx #(.BAUD(8)) dut8 (
        .clk  (clk),
        .rstn (rst8),
        .rx   (rx),
        .rd   (rd),
        .data (data8),
        .rcv  (rcv8),
        .ferr (ferr8),
        .ovr  (ovr8),
        .busy (busy8)
    );

    uart_rx #(.BAUD(104)) dut104 (
        .clk  (clk),
        .rstn (rst104),
        .rx   (rx),
        .rd   (rd),
        .data (data104),
        .rcv  (rcv104),
        .ferr (ferr104),
        .ovr  (ovr104),
        .busy (busy104)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
    endtask

    // rcv8 is snapshotted one cycle before and after the stop sample edge;
    // rdp raises rd exactly on that edge.
    task automatic send(input logic [7:0] b, input logic stopb,
                        input logic rdp, input int baud);
        rx = 1'b0;
        cyc(baud);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(baud);
        end
        rx = stopb;
        cyc(baud - 2);
        pre_rcv = rcv8;
        rd = rdp;
        cyc(1);
        rd = 1'b0;
        post_rcv = rcv8;
        cyc(1);
        rx = 1'b1;
    endtask

    initial begin
        rx     = 1'b1;
        rd     = 1'b0;
        rst8   = 1'b0;
        rst104 = 1'b0;
        cyc(3);
        chk8("rst_data", data8, 8'h00);
        chk1("rst_rcv", rcv8, 1'b0);
        chk1("rst_ferr", ferr8, 1'b0);
        chk1("rst_ovr", ovr8, 1'b0);
        chk1("rst_busy", busy8, 1'b0);
        chk1("rst_busy104", busy104, 1'b0);
        rst8   = 1'b1;
        rst104 = 1'b1;
        cyc(4);

        send(8'h55, 1'b1, 1'b0, 8);
        chk1("55_rcv_pre", pre_rcv, 1'b0);
        chk1("55_rcv_post", post_rcv, 1'b1);
        chk8("55_data", data8, 8'h55);
        chk1("55_ferr", ferr8, 1'b0);
        chk1("55_ovr", ovr8, 1'b0);
        chk1("55_busy", busy8, 1'b0);
        pulse_rd();
        chk1("55_rd_rcv", rcv8, 1'b0);
        chk8("55_rd_data", data8, 8'h55);

        send(8'hA3, 1'b1, 1'b0, 8);
        send(8'h3C, 1'b1, 1'b0, 8);
        chk8("b2b_data", data8, 8'hA3);
        chk1("b2b_ovr", ovr8, 1'b1);
        chk1("b2b_rcv", rcv8, 1'b1);
        pulse_rd();
        chk1("b2b_rd_rcv", rcv8, 1'b0);
        chk1("b2b_rd_ovr", ovr8, 1'b0);
        chk8("b2b_rd_data", data8, 8'hA3);

        send(8'h0F, 1'b0, 1'b0, 8);
        cyc(4);
        chk1("fe_ferr", ferr8, 1'b1);
        chk1("fe_rcv", rcv8, 1'b0);
        chk1("fe_busy", busy8, 1'b0);
        chk8("fe_data", data8, 8'hA3);
        pulse_rd();
        chk1("fe_rd_ferr", ferr8, 1'b0);
        rx = 1'b0;
        cyc(120);
        chk1("brk_ferr", ferr8, 1'b1);
        chk1("brk_busy", busy8, 1'b1);
        pulse_rd();
        chk1("brk_rd_ferr", ferr8, 1'b0);
        cyc(200);
        chk1("brk_once", ferr8, 1'b0);
        chk1("brk_hold_busy", busy8, 1'b1);
        rx = 1'b1;
        cyc(4);
        chk1("brk_end_busy", busy8, 1'b0);
        chk1("brk_end_ferr", ferr8, 1'b0);

        rx = 1'b0;
        cyc(2);
        rx = 1'b1;
        cyc(1);
        chk1("glitch_busy_hi", busy8, 1'b1);
        cyc(6);
        chk1("glitch_busy_lo", busy8, 1'b0);
        chk1("glitch_rcv", rcv8, 1'b0);
        chk1("glitch_ferr", ferr8, 1'b0);

        send(8'h7E, 1'b1, 1'b0, 8);
        chk8("rdacc_first", data8, 8'h7E);
        send(8'h81, 1'b1, 1'b1, 8);
        chk8("rdacc_data", data8, 8'h81);
        chk1("rdacc_rcv", rcv8, 1'b1);
        chk1("rdacc_ovr", ovr8, 1'b0);
        pulse_rd();
        chk1("rdacc_clr", rcv8, 1'b0);

        rst104 = 1'b0;
        cyc(2);
        rst104 = 1'b1;
        cyc(4);
        send(8'hA5, 1'b1, 1'b0, 104);
        chk8("b104_data", data104, 8'hA5);
        chk1("b104_rcv", rcv104, 1'b1);
        rx = 1'b0;
        cyc(104);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            cyc(104);
        end
        cyc(50);
        chk1("b104_busy_mid", busy104, 1'b1);
        rst104 = 1'b0;
        #2;
        chk8("b104_rst_data", data104, 8'h00);
        chk1("b104_rst_rcv", rcv104, 1'b0);
        chk1("b104_rst_ferr", ferr104, 1'b0);
        chk1("b104_rst_ovr", ovr104, 1'b0);
        chk1("b104_rst_busy", busy104, 1'b0);
        cyc(2);
        rst104 = 1'b1;
        cyc(104 * 6);
        chk1("b104_idle", busy104, 1'b0);
        send(8'h12, 1'b1, 1'b0, 104);
        chk8("b104_12_data", data104, 8'h12);
        chk1("b104_12_rcv", rcv104, 1'b1);
        chk1("b104_12_ferr", ferr104, 1'b0);
        chk1("b104_12_ovr", ovr104, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD, default `B115200 (104, from baudgen.vh), clock cycles per bit; legal range 4..65535.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rstn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 rx  input  1  serial line, idle high, 8N1, LSB first; asynchronous to clk.
REQ-005 rd  input  1  read acknowledge; one-cycle pulse consumes the held byte.
REQ-006 data  output  8  last accepted byte; stable while rcv=1.
REQ-007 rcv  output  1  byte available; level, held until rd.
REQ-008 ferr  output  1  framing error flag, sticky until rd.
REQ-009 ovr  output  1  overrun flag, sticky until rd.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 rx passes through a 2-flop synchronizer reset to 1; every reference to rx below means the synchronized value rxs.
REQ-012 FSM states: IDLE, START, DATA, STOP, WAITHI; one 16-bit cycle counter and one 3-bit bit index.
REQ-013 IDLE: rxs=0 -> START with counter cleared; otherwise stay.
REQ-014 START: on counter = BAUD/2 - 1 (integer division), sample rxs; 0 -> DATA with counter cleared and bit index 0; 1 -> IDLE (glitch rejected, no flag).
REQ-015 DATA: on counter = BAUD-1, shift rxs into shift register bit 7 (right shift), clear counter, increment index; after index 7 -> STOP.
REQ-016 STOP: on counter = BAUD-1, sample rxs; 1 -> IDLE and accept byte; 0 -> WAITHI, byte discarded, ferr<=1.
REQ-017 WAITHI: stay until rxs=1, then IDLE; a held-low line (break) produces exactly one ferr event.
REQ-018 Accept: if rcv=0 or rd=1 in the same cycle, data<=shift register and rcv<=1; if rcv=1 and rd=0, new byte dropped, data unchanged, ovr<=1.
REQ-019 rcv, data, ferr and ovr update on the clock edge after the stop-bit sample cycle.
REQ-020 rd with no accept in the same cycle: rcv<=0, ferr<=0, ovr<=0; data keeps its value.
REQ-021 rd with an accept in the same cycle: rcv stays 1, data takes the new byte, ovr cleared, ferr cleared.
REQ-022 rd with a framing error in the same cycle: ferr<=1 (set wins), rcv<=0.
REQ-023 rd while rcv=0 and flags clear has no effect.
REQ-024 Reception runs independently of rcv; a back-to-back frame (stop bit immediately followed by start bit) is received without loss.
REQ-025 Counter never wraps: it is cleared on every state transition and compared against BAUD-1 or BAUD/2-1 only.

Reset
REQ-026 rstn=0 forces asynchronously: state IDLE, counter 0, index 0, synchronizer 1/1, shift register 0, data=0, rcv=0, ferr=0, ovr=0, busy=0.
REQ-027 Reset asserted mid-frame aborts the frame with no output change other than the reset values; after release the block waits for a new falling edge.
REQ-028 Reset release while rx=0: the synchronizer sees 1 then 0, so START is entered and validated normally.

Verification (BAUD=8 unless stated)
REQ-029 Send 0x55, valid stop, rd held 0 -> rcv=1, data=0x55, ferr=0, ovr=0, rcv rising 1 clk after stop sample.
REQ-030 Send 0xA3 then 0x3C back-to-back, no rd -> data=0xA3, ovr=1, rcv=1; then rd pulse -> rcv=0, ovr=0, data=0xA3.
REQ-031 Send 0x0F with stop bit forced 0, then line high -> ferr=1, rcv=0; hold rx low 40 bit times -> no second ferr event; rd -> ferr=0.
REQ-032 rx low pulse of 2 clk in IDLE -> returns to IDLE, busy falls, rcv=0, ferr=0.
REQ-033 rd pulse on the exact accept cycle of a second byte 0x81 after first byte 0x7E -> rcv stays 1, data=0x81, ovr=0.
REQ-034 BAUD=104, rstn pulsed low during DATA bit 4 of 0xFF -> all outputs 0 immediately; next frame 0x12 received correctly.
